parity_check_arbiter: RTL and testbench

- Shares one 4-bit even-parity check datapath (data XOR-reduce, XOR with received parity bit; error=1 on mismatch) among N_REQ requesters.
- Round-robin grants one requester per cycle and registers the result in a one-entry output stage with valid/ready backpressure.
- Keeps per-requester saturating error counters.
- Sits between the nibble sources (link lanes) and the downstream status/logging consumer.

---
 rtl/parity_check_arbiter_pkg.sv | 21 ++
 rtl/parity_check_arbiter_if.sv | 32 +++
 rtl/parity_check_arbiter_rr_arbiter.sv | 48 ++++
 rtl/parity_check_arbiter.sv | 91 +++++++++
 tb/tb_parity_check_arbiter.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/parity_check_arbiter_pkg.sv
// Shared types and constants for the parity-check arbiter: response record
// and the error-counter saturation limit.
package parity_pkg;

    localparam int DW_DEFAULT = 4;
    localparam int ID_MAX_W   = 3;   // N_REQ tops out at 8
    localparam int DW_MAX     = 32;

    // All-ones value of a cnt_w-bit counter.
    function automatic longint unsigned err_cnt_max(input int cnt_w);
        return (longint'(1) << cnt_w) - 1;
    endfunction

    // Sized for the largest legal configuration; the top slices to its own widths.
    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [DW_MAX-1:0]   data;
        logic                error;
    } resp_t;

endpackage

// File: rtl/parity_check_arbiter_if.sv
// Request/response bundle between the link lanes, the arbiter and the status consumer.
interface parity_check_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = parity_pkg::DW_DEFAULT,
    parameter int CNT_W = 8
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*DW-1:0]    req_data;
    logic [N_REQ-1:0]       req_pbit;
    logic [N_REQ-1:0]       req_ready;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [ID_W-1:0]        resp_id;
    logic [DW-1:0]          resp_data;
    logic                   resp_error;
    logic [N_REQ*CNT_W-1:0] err_cnt;
    logic                   clr_cnt;
    logic                   busy;

    modport master (
        output req_valid, req_data, req_pbit, resp_ready, clr_cnt,
        input  req_ready, resp_valid, resp_id, resp_data, resp_error, err_cnt, busy
    );

    modport slave (
        input  req_valid, req_data, req_pbit, resp_ready, clr_cnt,
        output req_ready, resp_valid, resp_id, resp_data, resp_error, err_cnt, busy
    );

endinterface

// File: rtl/parity_check_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from the pointer upward;
// the pointer moves past the winner only when a grant is issued.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] gidx,
    output logic [$clog2(N_REQ)-1:0] ptr
);
    localparam int ID_W = $clog2(N_REQ);

    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] idx;
    logic            found;
    int              pos;

    always_comb begin
        gnt   = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = int'(ptr_q) + k;
            if (pos >= N_REQ) pos = pos - N_REQ;
            idx = ID_W'(pos);
            if (!found && en && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gidx     = idx;
            end
        end
        ptr_d = ptr_q;
        if (found) ptr_d = (gidx == ID_W'(N_REQ - 1)) ? '0 : gidx + ID_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/parity_check_arbiter.sv
// Shared even-parity checker for N_REQ link lanes with a one-entry
// valid/ready output stage and per-lane saturating error counters.
module parity_check_arbiter
    import parity_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = DW_DEFAULT,
    parameter int CNT_W = 8
) (
    input logic                   clk,
    input logic                   rst,
    parity_check_arbiter_if.slave bus
);
    localparam int ID_W = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(err_cnt_max(CNT_W));

    typedef enum logic {EMPTY, FULL} state_e;

    state_e                       state_q, state_d;
    resp_t                        resp_q, resp_d;
    logic [N_REQ-1:0][CNT_W-1:0]  cnt_q, cnt_d;

    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gidx;
    logic [ID_W-1:0]  rr_ptr_unused;
    logic             can_accept;
    logic [DW-1:0]    sel_data;
    logic             sel_err;

    assign can_accept = (state_q == EMPTY) || bus.resp_ready;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .clk  (clk),
        .rst  (rst),
        .en   (can_accept),
        .req  (bus.req_valid),
        .gnt  (gnt),
        .gidx (gidx),
        .ptr  (rr_ptr_unused)
    );

    // Single shared checker, muxed onto the granted lane.
    assign sel_data = bus.req_data[gidx*DW +: DW];
    assign sel_err  = (^sel_data) ^ bus.req_pbit[gidx];

    always_comb begin
        state_d = state_q;
        resp_d  = resp_q;
        if (|gnt) begin
            state_d = FULL;
            resp_d  = '{id: ID_MAX_W'(gidx), data: DW_MAX'(sel_data), error: sel_err};
        end else if (state_q == FULL && bus.resp_ready) begin
            state_d = EMPTY;
        end
    end

    // Counting happens at acceptance; clear wins over a same-cycle increment.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (bus.clr_cnt)
                cnt_d[i] = '0;
            else if (gnt[i] && sel_err && cnt_q[i] != CNT_MAX)
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            resp_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            resp_q  <= resp_d;
            cnt_q   <= cnt_d;
        end
    end

    logic resp_unused;
    assign resp_unused = ^{resp_q.id, resp_q.data};

    assign bus.req_ready  = gnt;
    assign bus.resp_valid = (state_q == FULL);
    assign bus.resp_id    = resp_q.id[ID_W-1:0];
    assign bus.resp_data  = resp_q.data[DW-1:0];
    assign bus.resp_error = resp_q.error;
    assign bus.err_cnt    = cnt_q;
    assign bus.busy       = (state_q == FULL) || (|bus.req_valid);

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Directed plus randomized check of parity_check_arbiter against a
// transaction-level model of grant order, held response and error counts.
module tb_parity_check_arbiter;
    localparam int N  = 4;
    localparam int DW = 4;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    parity_check_arbiter_if #(.N_REQ(N), .DW(DW), .CNT_W(CW)) bus ();
    parity_check_arbiter #(.N_REQ(N), .DW(DW), .CNT_W(CW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit live  = 0;

    // model state
    bit m_have;
    int m_id, m_data, m_err, m_ptr;
    int m_cnt [N];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lane_err(input int i);
        logic [DW-1:0] d;
        int ones;
        d = bus.req_data[i*DW +: DW];
        ones = 0;
        for (int b = 0; b < DW; b++) ones += int'(d[b]);
        return ((ones % 2) != int'(bus.req_pbit[i])) ? 1 : 0;
    endfunction

    function automatic int model_grant();
        if (m_have && !bus.resp_ready) return -1;
        for (int k = 0; k < N; k++)
            if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    task automatic model_edge(output int g);
        int e;
        g = -1;
        if (rst) begin
            m_have = 0; m_id = 0; m_data = 0; m_err = 0; m_ptr = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else begin
            g = model_grant();
            if (g >= 0) begin
                e = lane_err(g);
                m_have = 1; m_id = g; m_err = e;
                m_data = int'(bus.req_data[g*DW +: DW]);
                m_ptr  = (g + 1) % N;
                if (e != 0 && m_cnt[g] < CMAX) m_cnt[g]++;
            end else if (m_have && bus.resp_ready) begin
                m_have = 0;
            end
            if (bus.clr_cnt)
                for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (live) begin
            int g;
            g = model_grant();
            chk("req_ready", 64'(bus.req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
            chk("resp_valid", 64'(bus.resp_valid), 64'(m_have));
            if (m_have) begin
                chk("resp_id", 64'(bus.resp_id), 64'(m_id));
                chk("resp_data", 64'(bus.resp_data), 64'(m_data));
                chk("resp_error", 64'(bus.resp_error), 64'(m_err));
            end
            chk("busy", 64'(bus.busy), 64'(m_have || (|bus.req_valid)));
            for (int i = 0; i < N; i++)
                chk("err_cnt", 64'(bus.err_cnt[i*CW +: CW]), 64'(m_cnt[i]));
        end
    end

    int last_g;

    task automatic step();
        @(posedge clk);
        #1;
        model_edge(last_g);
        live = 1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                         input logic [N-1:0] p, input logic rr);
        bus.req_valid  = v;
        bus.req_data   = d;
        bus.req_pbit   = p;
        bus.resp_ready = rr;
    endtask

    initial begin
        rst = 1'b1;
        bus.clr_cnt = 1'b0;
        drive('0, '0, '0, 1'b0);
        step();
        step();
        rst = 1'b0;
        chk("reset_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("reset_resp_id", 64'(bus.resp_id), 64'd0);
        chk("reset_resp_error", 64'(bus.resp_error), 64'd0);
        chk("reset_err_cnt", 64'(bus.err_cnt), 64'd0);

        // single requester, good parity
        drive(4'b0001, 16'h000B, 4'b0001, 1'b1);
        #1 chk("single_ready", 64'(bus.req_ready), 64'b0001);
        step();
        drive('0, '0, '0, 1'b1);
        chk("single_valid", 64'(bus.resp_valid), 64'd1);
        chk("single_id", 64'(bus.resp_id), 64'd0);
        chk("single_err", 64'(bus.resp_error), 64'd0);
        chk("single_cnt0", 64'(bus.err_cnt[7:0]), 64'd0);

        // error path on requester 2
        drive(4'b0100, 16'h0A00, 4'b0100, 1'b1);
        step();
        drive('0, '0, '0, 1'b1);
        chk("err_id", 64'(bus.resp_id), 64'd2);
        chk("err_flag", 64'(bus.resp_error), 64'd1);
        chk("err_data", 64'(bus.resp_data), 64'hA);
        chk("err_cnt2", 64'(bus.err_cnt[23:16]), 64'd1);

        // fairness from a fresh pointer
        rst = 1'b1; step(); rst = 1'b0;
        drive(4'b1111, 16'h0000, 4'b0000, 1'b1);
        for (int k = 0; k < 6; k++) begin
            #1 chk("fair_ready", 64'(bus.req_ready), 64'd1 << (k % 4));
            step();
            chk("fair_id", 64'(bus.resp_id), 64'(k % 4));
        end

        // backpressure: hold response of requester 1
        bus.resp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 chk("bp_ready", 64'(bus.req_ready), 64'd0);
            chk("bp_id", 64'(bus.resp_id), 64'd1);
            chk("bp_valid", 64'(bus.resp_valid), 64'd1);
            step();
        end
        bus.resp_ready = 1'b1;
        #1 chk("bp_release_ready", 64'(bus.req_ready), 64'b0100);
        step();
        chk("bp_release_id", 64'(bus.resp_id), 64'd2);

        // saturation then clear with a same-cycle error
        rst = 1'b1; step(); rst = 1'b0;
        drive(4'b0010, 16'h0010, 4'b0000, 1'b1);
        for (int k = 0; k < 260; k++) step();
        chk("sat_cnt1", 64'(bus.err_cnt[15:8]), 64'd255);
        bus.clr_cnt = 1'b1;
        step();
        bus.clr_cnt = 1'b0;
        chk("clr_cnt1", 64'(bus.err_cnt[15:8]), 64'd0);

        // reset while FULL and holding
        step();
        bus.resp_ready = 1'b0;
        step();
        rst = 1'b1; step(); rst = 1'b0;
        drive(4'b1111, 16'h0000, 4'b0000, 1'b1);
        chk("rst_mid_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_mid_cnt", 64'(bus.err_cnt), 64'd0);
        #1 chk("rst_mid_first", 64'(bus.req_ready), 64'b0001);
        step();

        // randomized traffic; lanes hold their word until accepted
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i] || i == last_g) begin
                    bus.req_valid[i]          = ($urandom_range(0, 2) != 0);
                    bus.req_data[i*DW +: DW]  = DW'($urandom);
                    bus.req_pbit[i]           = 1'($urandom);
                end
            end
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            bus.clr_cnt    = ($urandom_range(0, 63) == 0);
            rst            = ($urandom_range(0, 499) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
